fsm_16_trace_checker: RTL and testbench

//  Sits directly downstream of the 16-state transition FSM (fsm_16). It snoops the FSM's

---
 rtl/fsm_16_trace_checker.sv | 212 +++++++++++++++++++++
 tb/tb_fsm_16_trace_checker.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/fsm_16_trace_checker.sv
// fsm_16_trace_checker
//   Watches the registered state of the 16-state transition FSM (fsm_16) along with
//   the input1/input2/fsm_reset lines it samples. From the sample taken at the previous
//   edge it predicts the state the FSM should hold now. It flags and counts mismatches,
//   keeps a visit bitmap and a transition count, and queues mismatch records in a
//   small FIFO that a consumer drains over a valid/ready port.
// Ports
//   clk, reset           clock; asynchronous active-low reset
//   enable, clear        sampling enable; synchronous clear of counters/flags/FIFO
//   fsm_reset            the FSM's own synchronous active-high reset line
//   input1, input2       FSM inputs
//   state                FSM registered state
//   err_pulse            one-cycle pulse per detected mismatch
//   err_sticky           set on first mismatch, held until clear/reset
//   err_count            saturating mismatch count
//   trace_count          saturating count of checked transitions
//   visited              bit n set once state n is sampled while enabled
//   trace_valid/ready    FIFO head handshake
//   trace_data           {prev_state, in1, in2, obs_state} of the head record
//   trace_ovf            sticky: a record was dropped because the FIFO was full
module fsm_16_trace_checker #(
  parameter int TRACE_DEPTH = 8,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             clear,
  input  logic             fsm_reset,
  input  logic             input1,
  input  logic             input2,
  input  logic [3:0]       state,
  output logic             err_pulse,
  output logic             err_sticky,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] trans_count,
  output logic [15:0]      visited,
  output logic             trace_valid,
  input  logic             trace_ready,
  output logic [9:0]       trace_data,
  output logic             trace_ovf
);

  localparam int              PTR_W    = $clog2(TRACE_DEPTH);
  localparam logic [PTR_W:0]  FULL_CNT = (PTR_W + 1)'(TRACE_DEPTH);

  typedef enum logic {IDLE = 1'b0, TRACK = 1'b1} chk_state_e;

  chk_state_e st_q, st_d;

  logic             have_prev, check, mismatch, full, pop, push;
  logic [3:0]       expect_state;
  logic [9:0]       record;

  logic [3:0]       p_state_q, p_state_d;
  logic             p_in1_q, p_in1_d, p_in2_q, p_in2_d, p_rst_q, p_rst_d;
  logic             err_pulse_q, err_pulse_d, err_sticky_q, err_sticky_d;
  logic             trace_ovf_q, trace_ovf_d;
  logic [CNT_W-1:0] err_count_q, err_count_d, trans_count_q, trans_count_d;
  logic [15:0]      visited_q, visited_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic [9:0]       mem_q [TRACE_DEPTH];
  logic [9:0]       mem_d [TRACE_DEPTH];

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // Expected FSM state given the previous sample. Only the low three state bits
  // select the condition, so S(k) and S(k+8) share a rule; S7/S15 go to 15 or wrap to 0.
  function automatic logic [3:0] predict(input logic [2:0] k, input logic a,
                                         input logic b, input logic r);
    logic cond;
    case (k)
      3'd0:    cond = a & b;
      3'd1:    cond = !a & b;
      3'd2:    cond = a & !b;
      3'd3:    cond = !a & !b;
      3'd4:    cond = a | b;
      3'd5:    cond = !a | b;
      3'd6:    cond = a | !b;
      default: cond = !a | !b;
    endcase
    if (r) return 4'h0;
    return cond ? {k, 1'b1} : ({k, 1'b0} + 4'd2);
  endfunction

  // Checker FSM: state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) st_q <= IDLE;
    else        st_q <= st_d;
  end

  // Checker FSM: next state
  always_comb begin
    st_d = st_q;
    if (clear || !enable) st_d = IDLE;
    else                  st_d = TRACK;
  end

  // Checker FSM: outputs
  always_comb begin
    have_prev = (st_q == TRACK);
    check     = have_prev && enable && !clear;
  end

  // Compare, count and queue
  always_comb begin
    expect_state = predict(p_state_q[2:0], p_in1_q, p_in2_q, p_rst_q);
    mismatch     = check && (state != expect_state);
    record       = {p_state_q, p_in1_q, p_in2_q, state};
    full         = (count_q == FULL_CNT);
    pop          = trace_valid && trace_ready;
    // A pop in the same cycle frees the slot the push needs.
    push         = mismatch && (!full || pop);

    p_state_d     = p_state_q;
    p_in1_d       = p_in1_q;
    p_in2_d       = p_in2_q;
    p_rst_d       = p_rst_q;
    err_pulse_d   = 1'b0;
    err_sticky_d  = err_sticky_q;
    err_count_d   = err_count_q;
    trans_count_d = trans_count_q;
    visited_d     = visited_q;
    trace_ovf_d   = trace_ovf_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    count_d       = count_q;
    mem_d         = mem_q;

    if (clear) begin
      err_sticky_d  = 1'b0;
      err_count_d   = '0;
      trans_count_d = '0;
      visited_d     = '0;
      trace_ovf_d   = 1'b0;
      wr_ptr_d      = '0;
      rd_ptr_d      = '0;
      count_d       = '0;
    end else begin
      if (enable) begin
        p_state_d        = state;
        p_in1_d          = input1;
        p_in2_d          = input2;
        p_rst_d          = fsm_reset;
        visited_d[state] = 1'b1;
      end
      if (check) trans_count_d = sat_inc(trans_count_q);
      if (mismatch) begin
        err_pulse_d  = 1'b1;
        err_sticky_d = 1'b1;
        err_count_d  = sat_inc(err_count_q);
        if (!push) trace_ovf_d = 1'b1;
      end
      if (push) begin
        mem_d[wr_ptr_q] = record;
        wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_pulse_q   <= 1'b0;
      err_sticky_q  <= 1'b0;
      err_count_q   <= '0;
      trans_count_q <= '0;
      visited_q     <= '0;
      trace_ovf_q   <= 1'b0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
    end else begin
      err_pulse_q   <= err_pulse_d;
      err_sticky_q  <= err_sticky_d;
      err_count_q   <= err_count_d;
      trans_count_q <= trans_count_d;
      visited_q     <= visited_d;
      trace_ovf_q   <= trace_ovf_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
    end
  end

  // History and record storage carry no reset; have_prev and the FIFO count guard them.
  always_ff @(posedge clk) begin
    p_state_q <= p_state_d;
    p_in1_q   <= p_in1_d;
    p_in2_q   <= p_in2_d;
    p_rst_q   <= p_rst_d;
    mem_q     <= mem_d;
  end

  assign err_pulse   = err_pulse_q;
  assign err_sticky  = err_sticky_q;
  assign err_count   = err_count_q;
  assign trans_count = trans_count_q;
  assign visited     = visited_q;
  assign trace_ovf   = trace_ovf_q;
  assign trace_valid = (count_q != '0);
  assign trace_data  = trace_valid ? mem_q[rd_ptr_q] : '0;

endmodule

// File: tb/tb_fsm_16_trace_checker.sv
module tb_fsm_16_trace_checker;

  logic        clk = 1'b0;
  logic        reset, enable, clear, fsm_reset, input1, input2, trace_ready;
  logic [3:0]  state;
  logic        err_pulse, err_sticky, trace_valid, trace_ovf;
  logic [15:0] err_count, trans_count, visited;
  logic [9:0]  trace_data;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [9:0]  exp_q[$];

  always #5 clk = ~clk;

  fsm_16_trace_checker #(.TRACE_DEPTH(8), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .enable(enable), .clear(clear),
    .fsm_reset(fsm_reset), .input1(input1), .input2(input2), .state(state),
    .err_pulse(err_pulse), .err_sticky(err_sticky), .err_count(err_count),
    .trans_count(trans_count), .visited(visited), .trace_valid(trace_valid),
    .trace_ready(trace_ready), .trace_data(trace_data), .trace_ovf(trace_ovf)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [9:0] rec(input logic [3:0] p, input logic a, input logic b,
                                     input logic [3:0] o);
    return {p, a, b, o};
  endfunction

  // Monitor: every record the DUT hands over must be the next expected one.
  always @(negedge clk) begin
    if (reset && trace_valid && trace_ready) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL trace_unexpected: got 0x%0h, expected no record", trace_data);
      end else begin
        chk("trace_data", trace_data, exp_q.pop_front());
      end
    end
  end

  task automatic step(input logic [3:0] s, input logic a, input logic b, input logic fr,
                      input logic exp_pulse);
    enable = 1'b1; state = s; input1 = a; input2 = b; fsm_reset = fr;
    @(posedge clk); #1;
    chk("err_pulse", err_pulse, exp_pulse);
  endtask

  task automatic idle();
    enable = 1'b0;
    @(posedge clk); #1;
    chk("err_pulse_idle", err_pulse, 0);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_err_pulse"},   err_pulse,   0);
    chk({tag, "_err_sticky"},  err_sticky,  0);
    chk({tag, "_err_count"},   err_count,   0);
    chk({tag, "_trans_count"}, trans_count, 0);
    chk({tag, "_visited"},     visited,     0);
    chk({tag, "_trace_valid"}, trace_valid, 0);
    chk({tag, "_trace_data"},  trace_data,  0);
    chk({tag, "_trace_ovf"},   trace_ovf,   0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
    $fatal(1);
  end

  initial begin
    reset = 1'b0; enable = 1'b0; clear = 1'b0; fsm_reset = 1'b0;
    input1 = 1'b0; input2 = 1'b0; state = 4'h0; trace_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    reset = 1'b1;

    // Legal walk 0 -> 1 -> 3
    step(4'd0, 1, 1, 0, 0);
    step(4'd1, 0, 1, 0, 0);
    step(4'd3, 0, 0, 0, 0);
    chk("walk_trans_count", trans_count, 2);
    chk("walk_err_count", err_count, 0);
    chk("walk_visited", visited, 16'h000B);

    // Wrap rules: 3(00)->7, 7(11)->0, then 15(10)->15
    step(4'd7, 1, 1, 0, 0);
    step(4'd0, 0, 0, 0, 0);
    idle();
    step(4'd15, 1, 0, 0, 0);
    step(4'd15, 0, 0, 0, 0);
    chk("wrap_err_count", err_count, 0);
    chk("wrap_trans_count", trans_count, 5);
    chk("wrap_visited", visited, 16'h808B);
    chk("wrap_sticky", err_sticky, 0);

    // Injected fault: 2(10) should go to 5, FSM shows 6
    idle();
    step(4'd2, 1, 0, 0, 0);
    exp_q.push_back(rec(4'd2, 1, 0, 4'd6));
    step(4'd6, 0, 0, 0, 1);
    chk("fault_trace_data", trace_data, 10'h0A6);
    chk("fault_sticky", err_sticky, 1);
    chk("fault_err_count", err_count, 1);
    step(4'd13, 0, 0, 0, 0);
    chk("fault_trans_count", trans_count, 7);
    chk("fault_drained", trace_valid, 0);

    // Overflow: nine mismatches with the consumer stalled
    trace_ready = 1'b0;
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    chk("clr_err_count", err_count, 0);
    chk("clr_trans_count", trans_count, 0);
    chk("clr_visited", visited, 0);
    chk("clr_sticky", err_sticky, 0);
    step(4'd1, 1, 1, 0, 0);
    for (int i = 2; i <= 10; i++) begin
      if (i <= 9) exp_q.push_back(rec(4'(i - 1), 1, 1, 4'(i)));
      step(4'(i), 1, 1, 0, 1);
      if (i == 9) chk("ovf_not_yet", trace_ovf, 0);
    end
    chk("ovf_flag", trace_ovf, 1);
    chk("ovf_err_count", err_count, 9);
    chk("ovf_trans_count", trans_count, 9);
    chk("ovf_valid", trace_valid, 1);
    chk("ovf_head_stable", trace_data, 10'h072);
    trace_ready = 1'b1;
    repeat (8) idle();
    chk("ovf_drained_valid", trace_valid, 0);
    chk("ovf_drained_queue", exp_q.size(), 0);

    // fsm_reset: 9 with reset goes to 0; without honouring it 9(10) would predict 4
    idle();
    step(4'd9, 1, 0, 1, 0);
    step(4'd0, 0, 0, 0, 0);
    idle();
    step(4'd9, 1, 0, 1, 0);
    exp_q.push_back(rec(4'd9, 1, 0, 4'd4));
    step(4'd4, 0, 0, 0, 1);
    chk("frst_err_count", err_count, 10);
    chk("frst_trans_count", trans_count, 11);
    chk("frst_ovf_held", trace_ovf, 1);

    // clear wins over a same-cycle mismatch (4(00) predicts 10, 3 presented)
    enable = 1'b1; state = 4'd3; input1 = 1'b0; input2 = 1'b0; clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    check_all_zero("clear");

    // Async reset with five records queued
    trace_ready = 1'b0;
    step(4'd1, 1, 1, 0, 0);
    for (int i = 2; i <= 6; i++) step(4'(i), 1, 1, 0, 1);
    chk("burst_valid", trace_valid, 1);
    chk("burst_err_count", err_count, 5);
    #2;
    reset = 1'b0;
    #1;
    check_all_zero("async");
    @(posedge clk); #1;
    reset = 1'b1;
    trace_ready = 1'b1;
    step(4'd0, 1, 1, 0, 0);
    chk("post_rst_trans_count", trans_count, 0);
    chk("post_rst_err_count", err_count, 0);
    chk("post_rst_valid", trace_valid, 0);
    step(4'd1, 0, 0, 0, 0);
    chk("post_rst_checked", trans_count, 1);
    chk("post_rst_no_err", err_count, 0);

    chk("final_queue_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
